mul_sequencer: RTL

Iterative multiply controller for the multi-cycle core. It takes the register operands already selected for MUL, UMULL and SMULL, runs a fixed-latency radix-2 shift-add sequence, and returns the 64-bit product. It also returns per-half write enables for the register file (RdLo on WA3, RdHi on WA4) and N/Z flag candidates. The main control FSM holds its multiply state until `done` pulses.

---
 rtl/mul_pkg.sv | 14 +
 rtl/mul_shift_add.sv | 38 +++
 rtl/mul_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative multiply sequencer.
package mul_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = $clog2(MUL_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mul_state_t;

endpackage

// File: rtl/mul_shift_add.sv
// Radix-2 shift-add datapath: accumulator, multiplicand and multiplier
// registers, advanced by one add/shift step per enabled cycle.
import mul_pkg::*;

module mul_shift_add #(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     mcand_in,
  input  logic [WIDTH-1:0]     mplier_in,
  output logic [2*WIDTH-1:0]   acc
);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, mcand_in};
      mplier <= mplier_in;
    end else if (step) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Iterative multiply controller for MUL/UMULL/SMULL: sign handling, fixed
// WIDTH+2 cycle sequence, register-file write enables and N/Z candidates.
import mul_pkg::*;

module mul_sequencer #(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mul_long,
  input  logic             is_signed,
  input  logic             abort,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             we_lo,
  output logic             we_hi,
  output logic             flag_n,
  output logic             flag_z,
  output mul_state_t       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);

  // Handshake: start is a request taken only in IDLE (busy low); there is no
  // queueing. done is a single-cycle pulse with no backpressure, and abort
  // overrides every transition, returning the sequencer to IDLE.

  mul_state_t           state;
  logic [CNT_W-1:0]     cnt;
  logic                 long_q;
  logic                 neg_q;
  logic [2*WIDTH-1:0]   product_q;
  logic [2*WIDTH-1:0]   acc;
  logic                 sgn;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic                 load;
  logic                 step;

  assign sgn   = is_signed & mul_long;
  // Two's-complement of the most negative value yields 2^(WIDTH-1) unsigned.
  assign mag_a = (sgn && op_a[WIDTH-1]) ? -op_a : op_a;
  assign mag_b = (sgn && op_b[WIDTH-1]) ? -op_b : op_b;

  assign load = (state == IDLE) && start && !abort;
  assign step = (state == CALC) && !abort;

  mul_shift_add #(.WIDTH(WIDTH)) u_shift_add (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .step      (step),
    .mcand_in  (mag_a),
    .mplier_in (mag_b),
    .acc       (acc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      long_q    <= 1'b0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            long_q <= mul_long;
            neg_q  <= sgn & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            cnt    <= CNT_W'(WIDTH - 1);
            state  <= CALC;
          end
        end
        CALC: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= FIX;
          end
        end
        FIX: begin
          product_q <= neg_q ? -acc : acc;
          state     <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign we_lo     = done;
  assign we_hi     = done & long_q;
  assign result_lo = product_q[WIDTH-1:0];
  assign result_hi = product_q[2*WIDTH-1:WIDTH];

  always_comb begin
    flag_n = 1'b0;
    flag_z = 1'b0;
    if (done) begin
      if (long_q) begin
        flag_n = product_q[2*WIDTH-1];
        flag_z = (product_q == '0);
      end else begin
        flag_n = product_q[WIDTH-1];
        flag_z = (product_q[WIDTH-1:0] == '0);
      end
    end
  end

endmodule
